pipe_ctrl_unit: RTL and testbench
=================================

// Module: pipe_ctrl_unit
// PURPOSE
// - Pipelined successor of the single-cycle opcode decoder for the RV32I core.
// - Decodes the ID-stage instruction into a control word and carries it through the ID/EX, EX/MEM and MEM/WB registers.
// - Detects load-use hazards (stall), squashes instructions behind a taken branch/jump (flush) and produces EX-stage forwarding selects.
// - Every decoded field is a defined value (no x); unsupported opcodes decode to a bubble.
// PARAMETERS
// - REG_ADDR_W       5  register-index width
// - LOAD_USE_STALLS  1  bubbles inserted per load-use hazard (1..3, covers multi-cycle data memory)
// - FLUSH_DEPTH      2  IDs squashed per taken redirect: the current one plus FLUSH_DEPTH-1 following (1..3)
// PORTS
// - clk           in   1   single clock, rising edge
// - rst           in   1   asynchronous, active-high reset
// - instr_id      in   32  instruction currently in ID
// - id_valid      in   1   instr_id holds a real instruction
// - ex_taken      in   1   branch/JAL/JALR in EX resolved taken (redirect)
// - stall         out  1   hold PC and IF/ID register this cycle
// - ex_ALUop      out  2   EX ALU operation class
// - ex_ALUsrc     out  1   0=rs2, 1=immediate
// - ex_LUIorAUIPC out  1   1=LUI, 0=AUIPC
// - ex_Jump       out  2   00 none, 01 JAL, 10 JALR
// - ex_rs1/ex_rs2 out  REG_ADDR_W  source indices in EX
// - mem_MemRead   out  1   load in MEM
// - mem_MemWrite  out  1   store in MEM
// - wb_RegWrite   out  1   register-file write enable in WB
// - wb_MemToReg   out  2   00 mem, 01 ALU, 10 PC+4, 11 upper-immediate
// - ex_rd/mem_rd/wb_rd  out  REG_ADDR_W  destination index per stage
// - fwd_a/fwd_b   out  2   EX operand select: 00 regfile, 10 from MEM, 01 from WB
// - illegal       out  1   see CONFIGURATION
// BEHAVIOUR
// - Decode (combinational; fields in order ALUop/ALUsrc/MemRead/MemWrite/RegWrite/MemToReg/Jump/LUIorAUIPC):
//   - LOAD:   01/1/1/0/1/00/00/0
//   - STORE:  01/1/0/1/0/00/00/0
//   - R-type: 10/0/0/0/1/01/00/0
//   - BRANCH: 11/0/0/0/0/00/00/0
//   - OP-IMM: 00/1/0/0/1/01/00/0
//   - LUI:    00/0/0/0/1/11/00/1
//   - AUIPC:  00/0/0/0/1/11/00/0
//   - JALR:   01/1/0/0/1/10/10/0
//   - JAL:    00/0/0/0/1/10/01/0
//   - Other opcode or id_valid=0: bubble (all zero, rd=0).
// - Reset: every output and every pipeline register goes to 0 asynchronously; stall=0; stall/flush counters cleared.
// - Pipeline advance: ID/EX loads the decode each cycle; EX/MEM and MEM/WB advance every cycle (stall never freezes EX..WB).
// - Latency: the decode appears on ex_* 1 cycle after ID, mem_* after 2, wb_* after 3.
// - Load-use: hazard = ex MemRead and ex_rd!=0 and ex_rd matches rs1 (or rs2 where the opcode reads it) of instr_id.
//   - On a hazard, stall=1 for LOAD_USE_STALLS consecutive cycles (counter); a bubble is loaded into ID/EX each of those cycles.
//   - Hazards are not re-detected while the counter is non-zero.
// - Flush: ex_taken=1 loads a bubble into ID/EX that cycle and for the next FLUSH_DEPTH-1 cycles (counter).
//   - Flush has priority over stall: it clears the stall counter and drops stall the same cycle.
//   - A second ex_taken during a flush is ignored: squashed slots cannot hold jumps.
// - Forwarding (combinational on registered state), per operand:
//   - 10 when mem RegWrite, mem_rd!=0 and mem_rd==ex_rsX;
//   - else 01 when wb_RegWrite, wb_rd!=0 and wb_rd==ex_rsX;
//   - else 00. MEM has priority over WB.
// - x0 is never a hazard or forwarding source.
// - Reset mid-stall or mid-flush: counters zero immediately, the pipeline restarts empty.
// CONFIGURATION
// - CTRL_ILLEGAL_TRAP_EN defined: an unsupported opcode with id_valid=1 (and not squashed or stalled) sets illegal=1.
//   - illegal is registered and aligned with the EX stage, a 1-cycle pulse; the instruction still proceeds as a bubble.
// - CTRL_ILLEGAL_TRAP_EN undefined: illegal is tied to 0 and unsupported opcodes become silent bubbles.
// TESTING
// - Reset with rst=1 mid-stream: all outputs 0 immediately; after release, ADD x3,x1,x2 gives ex_ALUop=10 one cycle later and wb_RegWrite=1, wb_rd=3 three cycles later.
// - LW x5,0(x1) then ADD x6,x5,x2 with LOAD_USE_STALLS=1: stall=1 for exactly 1 cycle; the bubble has ex_* all 0; then ADD reaches EX with fwd_a=01.
// - ADDI x4,x0,1 then SUB x7,x4,x4: no stall; fwd_a=fwd_b=10.
// - Add ADD x8,x0,x4 after a 1-cycle gap: fwd_a=00, fwd_b=01.
// - ex_taken=1 with FLUSH_DEPTH=2: the next 2 EX slots are bubbles; a simultaneous load-use stall is cancelled (stall=0).
// - Write to x0 (ADDI x0,x0,5) followed by a user of x0: no stall, fwd=00.
// - Opcode 7'b1111111 with the macro defined: illegal pulses 1 cycle with ex_* all 0. Without the macro: illegal stays 0.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// ============================================================================
// Module      : pipe_ctrl_unit
// Description : RV32I pipelined control unit. It decodes the ID-stage
//               instruction and carries the control word through ID/EX,
//               EX/MEM and MEM/WB. It also provides load-use stall, redirect
//               flush and EX-stage forwarding selects.
//               Optional feature macro: CTRL_ILLEGAL_TRAP_EN (illegal-opcode
//               pulse aligned with EX).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_ctrl_unit #(
    parameter int REG_ADDR_W      = 5,
    parameter int LOAD_USE_STALLS = 1,
    parameter int FLUSH_DEPTH     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           instr_id,
    input  logic                  id_valid,
    input  logic                  ex_taken,
    output logic                  stall,
    output logic [1:0]            ex_ALUop,
    output logic                  ex_ALUsrc,
    output logic                  ex_LUIorAUIPC,
    output logic [1:0]            ex_Jump,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic                  mem_MemRead,
    output logic                  mem_MemWrite,
    output logic                  wb_RegWrite,
    output logic [1:0]            wb_MemToReg,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  illegal
);

    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    localparam logic [1:0] c_STALL_RELOAD = 2'(LOAD_USE_STALLS - 1);
    localparam logic [1:0] c_FLUSH_RELOAD = 2'(FLUSH_DEPTH - 1);

    typedef struct packed {
        logic [1:0]            alu_op;
        logic                  alu_src;
        logic                  lui;
        logic [1:0]            jump;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
        logic [1:0]            mem_to_reg;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
    } ctrl_t;

    ctrl_t                 w_dec;
    ctrl_t                 w_id_ex_next;
    ctrl_t                 r_ex;
    logic                  w_known;
    logic                  w_uses_rs1;
    logic                  w_uses_rs2;
    logic                  w_hazard;
    logic                  w_flush_new;
    logic                  w_flush;
    logic                  w_stall;
    logic [1:0]            r_stall_cnt;
    logic [1:0]            r_flush_cnt;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic                  r_mem_reg_write;
    logic [1:0]            r_mem_mem_to_reg;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic                  r_wb_reg_write;
    logic [1:0]            r_wb_mem_to_reg;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic                  w_unused_bits;

    // funct3/funct7 only matter to the ALU decoder, not to this unit.
    assign w_unused_bits = ^{instr_id[31:25], instr_id[14:12]};

    // Source/destination indices are zeroed when the opcode does not use
    // them, so stale immediate bits can never trigger a hazard or forward.
    always_comb begin
        w_dec      = '0;
        w_known    = 1'b0;
        w_uses_rs1 = 1'b0;
        w_uses_rs2 = 1'b0;
        case (instr_id[6:0])
            c_OP_LOAD: begin
                w_known = 1'b1; w_uses_rs1 = 1'b1;
                w_dec.alu_op = 2'b01; w_dec.alu_src = 1'b1;
                w_dec.mem_read = 1'b1; w_dec.reg_write = 1'b1;
                w_dec.mem_to_reg = 2'b00;
            end
            c_OP_STORE: begin
                w_known = 1'b1; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
                w_dec.alu_op = 2'b01; w_dec.alu_src = 1'b1;
                w_dec.mem_write = 1'b1;
            end
            c_OP_RTYPE: begin
                w_known = 1'b1; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
                w_dec.alu_op = 2'b10; w_dec.reg_write = 1'b1;
                w_dec.mem_to_reg = 2'b01;
            end
            c_OP_BRANCH: begin
                w_known = 1'b1; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
                w_dec.alu_op = 2'b11;
            end
            c_OP_OPIMM: begin
                w_known = 1'b1; w_uses_rs1 = 1'b1;
                w_dec.alu_op = 2'b00; w_dec.alu_src = 1'b1;
                w_dec.reg_write = 1'b1; w_dec.mem_to_reg = 2'b01;
            end
            c_OP_LUI: begin
                w_known = 1'b1;
                w_dec.reg_write = 1'b1; w_dec.mem_to_reg = 2'b11;
                w_dec.lui = 1'b1;
            end
            c_OP_AUIPC: begin
                w_known = 1'b1;
                w_dec.reg_write = 1'b1; w_dec.mem_to_reg = 2'b11;
            end
            c_OP_JALR: begin
                w_known = 1'b1; w_uses_rs1 = 1'b1;
                w_dec.alu_op = 2'b01; w_dec.alu_src = 1'b1;
                w_dec.reg_write = 1'b1; w_dec.mem_to_reg = 2'b10;
                w_dec.jump = 2'b10;
            end
            c_OP_JAL: begin
                w_known = 1'b1;
                w_dec.reg_write = 1'b1; w_dec.mem_to_reg = 2'b10;
                w_dec.jump = 2'b01;
            end
            default: w_known = 1'b0;
        endcase
        if (w_uses_rs1) w_dec.rs1 = REG_ADDR_W'(instr_id[19:15]);
        if (w_uses_rs2) w_dec.rs2 = REG_ADDR_W'(instr_id[24:20]);
        if (w_dec.reg_write) w_dec.rd = REG_ADDR_W'(instr_id[11:7]);
        if (!id_valid || !w_known) w_dec = '0;
    end

    assign w_hazard = r_ex.mem_read && (r_ex.rd != '0) &&
                      ((w_dec.rs1 == r_ex.rd) || (w_dec.rs2 == r_ex.rd));

    // A redirect arriving while a flush is already running is ignored.
    assign w_flush_new = ex_taken && (r_flush_cnt == 2'd0);
    assign w_flush     = w_flush_new || (r_flush_cnt != 2'd0);
    assign w_stall     = !w_flush && ((r_stall_cnt != 2'd0) || w_hazard);
    assign stall       = w_stall;

    assign w_id_ex_next = (w_flush || w_stall) ? ctrl_t'('0) : w_dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 2'd0;
            r_flush_cnt <= 2'd0;
        end else begin
            if (w_flush_new)
                r_flush_cnt <= c_FLUSH_RELOAD;
            else if (r_flush_cnt != 2'd0)
                r_flush_cnt <= r_flush_cnt - 2'd1;

            if (w_flush)
                r_stall_cnt <= 2'd0;
            else if (r_stall_cnt != 2'd0)
                r_stall_cnt <= r_stall_cnt - 2'd1;
            else if (w_hazard)
                r_stall_cnt <= c_STALL_RELOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex             <= '0;
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_reg_write  <= 1'b0;
            r_mem_mem_to_reg <= 2'b00;
            r_mem_rd         <= '0;
            r_wb_reg_write   <= 1'b0;
            r_wb_mem_to_reg  <= 2'b00;
            r_wb_rd          <= '0;
        end else begin
            r_ex             <= w_id_ex_next;
            r_mem_read       <= r_ex.mem_read;
            r_mem_write      <= r_ex.mem_write;
            r_mem_reg_write  <= r_ex.reg_write;
            r_mem_mem_to_reg <= r_ex.mem_to_reg;
            r_mem_rd         <= r_ex.rd;
            r_wb_reg_write   <= r_mem_reg_write;
            r_wb_mem_to_reg  <= r_mem_mem_to_reg;
            r_wb_rd          <= r_mem_rd;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_illegal <= 1'b0;
        else
            r_illegal <= id_valid && !w_known && !w_flush && !w_stall;
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    // MEM is the younger producer, so it wins over WB.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (r_mem_reg_write && (r_mem_rd != '0) && (r_mem_rd == r_ex.rs1))
            fwd_a = 2'b10;
        else if (r_wb_reg_write && (r_wb_rd != '0) && (r_wb_rd == r_ex.rs1))
            fwd_a = 2'b01;
        if (r_mem_reg_write && (r_mem_rd != '0) && (r_mem_rd == r_ex.rs2))
            fwd_b = 2'b10;
        else if (r_wb_reg_write && (r_wb_rd != '0) && (r_wb_rd == r_ex.rs2))
            fwd_b = 2'b01;
    end

    assign ex_ALUop      = r_ex.alu_op;
    assign ex_ALUsrc     = r_ex.alu_src;
    assign ex_LUIorAUIPC = r_ex.lui;
    assign ex_Jump       = r_ex.jump;
    assign ex_rs1        = r_ex.rs1;
    assign ex_rs2        = r_ex.rs2;
    assign ex_rd         = r_ex.rd;
    assign mem_MemRead   = r_mem_read;
    assign mem_MemWrite  = r_mem_write;
    assign mem_rd        = r_mem_rd;
    assign wb_RegWrite   = r_wb_reg_write;
    assign wb_MemToReg   = r_wb_mem_to_reg;
    assign wb_rd         = r_wb_rd;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_unit.sv
// ============================================================================
// Module      : tb_pipe_ctrl_unit
// Description : Directed self-checking bench for pipe_ctrl_unit (default
//               parameters; expectations follow CTRL_ILLEGAL_TRAP_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl_unit;

    logic        clk;
    logic        rst;
    logic [31:0] instr_id;
    logic        id_valid;
    logic        ex_taken;
    logic        stall;
    logic [1:0]  ex_ALUop;
    logic        ex_ALUsrc;
    logic        ex_LUIorAUIPC;
    logic [1:0]  ex_Jump;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic        mem_MemRead;
    logic        mem_MemWrite;
    logic        wb_RegWrite;
    logic [1:0]  wb_MemToReg;
    logic [4:0]  ex_rd;
    logic [4:0]  mem_rd;
    logic [4:0]  wb_rd;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic        illegal;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_ctrl_unit dut (
        .clk(clk), .rst(rst), .instr_id(instr_id), .id_valid(id_valid),
        .ex_taken(ex_taken), .stall(stall), .ex_ALUop(ex_ALUop),
        .ex_ALUsrc(ex_ALUsrc), .ex_LUIorAUIPC(ex_LUIorAUIPC),
        .ex_Jump(ex_Jump), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .wb_RegWrite(wb_RegWrite), .wb_MemToReg(wb_MemToReg),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .illegal(illegal)
    );

    wire [41:0] all_out = {stall, ex_ALUop, ex_ALUsrc, ex_LUIorAUIPC, ex_Jump,
                           ex_rs1, ex_rs2, mem_MemRead, mem_MemWrite,
                           wb_RegWrite, wb_MemToReg, ex_rd, mem_rd, wb_rd,
                           fwd_a, fwd_b, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        id_valid = 1'b0;
        instr_id = 32'd0;
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rd,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm,
        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd,
        input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    task automatic issue(input logic [31:0] ins);
        instr_id = ins;
        id_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1; instr_id = 32'd0; id_valid = 1'b0; ex_taken = 1'b0;
        tick(); tick();
        check("reset_outputs", 64'(all_out), 64'd0);
        rst = 1'b0;

        // SW, JAL x1, LUI x10 back to back
        issue({7'd0, 5'd2, 5'd1, 3'b010, 5'd0, 7'b0100011});
        tick();
        check("sw_ex_alusrc", 64'(ex_ALUsrc), 64'd1);
        check("sw_ex_aluop", 64'(ex_ALUop), 64'd1);
        issue({20'd0, 5'd1, 7'b1101111});
        tick();
        check("jal_ex_jump", 64'(ex_Jump), 64'd1);
        check("sw_mem_write", 64'(mem_MemWrite), 64'd1);
        issue({20'h12345, 5'd10, 7'b0110111});
        tick();
        check("lui_ex_flag", 64'(ex_LUIorAUIPC), 64'd1);
        check("sw_wb_regwrite", 64'(wb_RegWrite), 64'd0);
        issue(enc_i(12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011));
        tick();
        check("jal_wb_mtr", 64'(wb_MemToReg), 64'd2);
        check("jal_wb_rd", 64'(wb_rd), 64'd1);

        // Asynchronous reset in mid-stream
        #2 rst = 1'b1;
        #1 check("midreset_outputs", 64'(all_out), 64'd0);
        id_valid = 1'b0;
        tick();
        rst = 1'b0;

        issue(enc_r(5'd3, 5'd1, 5'd2, 7'd0));
        tick();
        check("add_ex_aluop", 64'(ex_ALUop), 64'd2);
        check("add_ex_rs", 64'({ex_rs1, ex_rs2, ex_rd}), 64'({5'd1, 5'd2, 5'd3}));
        drain(2);
        check("add_wb", 64'({wb_RegWrite, wb_rd, wb_MemToReg}),
              64'({1'b1, 5'd3, 2'b01}));
        drain(2);

        // Load-use: LW x5 then ADD x6,x5,x2
        issue(enc_i(12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011));
        tick();
        issue(enc_r(5'd6, 5'd5, 5'd2, 7'd0));
        #1 check("lu_stall", 64'(stall), 64'd1);
        tick();
        check("lu_bubble", 64'({ex_ALUop, ex_ALUsrc, ex_Jump, ex_rd, ex_rs1}), 64'd0);
        check("lu_mem_read", 64'(mem_MemRead), 64'd1);
        check("lu_stall_drop", 64'(stall), 64'd0);
        tick();
        check("lu_add_ex", 64'({ex_ALUop, ex_rd}), 64'({2'b10, 5'd6}));
        check("lu_fwd", 64'({fwd_a, fwd_b}), 64'({2'b01, 2'b00}));
        drain(3);

        // ADDI x4,x0,1 ; SUB x7,x4,x4 ; ADD x8,x0,x4
        issue(enc_i(12'd1, 5'd0, 3'b000, 5'd4, 7'b0010011));
        tick();
        issue(enc_r(5'd7, 5'd4, 5'd4, 7'b0100000));
        #1 check("sub_no_stall", 64'(stall), 64'd0);
        tick();
        check("sub_fwd", 64'({fwd_a, fwd_b}), 64'({2'b10, 2'b10}));
        issue(enc_r(5'd8, 5'd0, 5'd4, 7'd0));
        tick();
        check("add8_fwd", 64'({fwd_a, fwd_b}), 64'({2'b00, 2'b01}));
        drain(3);

        // x0 destination never stalls or forwards
        issue(enc_i(12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011));
        tick();
        issue(enc_r(5'd9, 5'd0, 5'd0, 7'd0));
        #1 check("x0_no_stall", 64'(stall), 64'd0);
        tick();
        check("x0_fwd", 64'({fwd_a, fwd_b}), 64'd0);
        issue(enc_i(12'd5, 5'd0, 3'b000, 5'd0, 7'b0010011));
        tick();
        issue(enc_r(5'd9, 5'd0, 5'd0, 7'd0));
        tick();
        check("x0_addi_fwd", 64'({fwd_a, fwd_b}), 64'd0);
        drain(3);

        // Flush overrides a simultaneous load-use stall
        issue(enc_i(12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011));
        tick();
        issue(enc_r(5'd6, 5'd5, 5'd2, 7'd0));
        ex_taken = 1'b1;
        #1 check("flush_stall_cancel", 64'(stall), 64'd0);
        tick();
        check("flush_slot1", 64'({ex_ALUop, ex_rd, ex_rs1, ex_rs2}), 64'd0);
        ex_taken = 1'b1;
        tick();
        ex_taken = 1'b0;
        check("flush_slot2", 64'({ex_ALUop, ex_rd, ex_rs1, ex_rs2}), 64'd0);
        tick();
        check("flush_resume", 64'({ex_ALUop, ex_rd}), 64'({2'b10, 5'd6}));
        drain(3);

        // Unsupported opcode
        issue(32'hFFFF_FFFF);
        tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
        check("illegal_pulse", 64'(illegal), 64'd1);
`else
        check("illegal_tied", 64'(illegal), 64'd0);
`endif
        check("illegal_bubble", 64'({ex_ALUop, ex_ALUsrc, ex_Jump, ex_rd, ex_rs1, ex_rs2}), 64'd0);
        drain(1);
        check("illegal_clear", 64'(illegal), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
